// File: rtl/axis_spi_adc_pair.sv
// SPI master for a two-channel ADC: every SAMPLE_INTERVAL clocks it reads ch0 then ch1
// and presents each 16-bit result on a valid/ready word stream, m_last marking ch1.
module axis_spi_adc_pair #(
    parameter int unsigned CLK_DIV         = 4,
    parameter int unsigned SAMPLE_INTERVAL = 1000,
    parameter logic [15:0] CMD_CH0         = 16'h0000,
    parameter logic [15:0] CMD_CH1         = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso,
    output logic        m_valid,
    output logic [15:0] m_data,
    output logic        m_last,
    input  logic        m_ready,
    output logic        overrun
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned INT_W = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [INT_W-1:0] INT_LAST = INT_W'(SAMPLE_INTERVAL - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD,
        GAP,
        WAIT_OUT
    } state_e;

    state_e            state_q, state_d;
    logic [INT_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [4:0]        bit_q, bit_d;
    logic              ch_q, ch_d;
    logic [15:0]       sout_q, sout_d;
    logic [15:0]       sin_q, sin_d;
    logic              m_valid_q, m_valid_d;
    logic [15:0]       m_data_q, m_data_d;
    logic              m_last_q, m_last_d;
    logic              overrun_q, overrun_d;

    logic              tick;
    logic              out_free;
    logic              phase_done;
    logic              load;
    logic              in_frame;

    always_comb begin
        tick = enable && (cnt_q == INT_LAST);
        if (!enable || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + INT_W'(1);
        end
    end

    // NOTE: every next-state variable gets its hold value first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        div_d     = '0;
        bit_d     = bit_q;
        ch_d      = ch_q;
        sout_d    = sout_q;
        sin_d     = sin_q;
        m_valid_d = m_valid_q && !m_ready;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        overrun_d = 1'b0;
        load      = 1'b0;

        phase_done = (div_q == DIV_LAST);
        out_free   = !m_valid_q || m_ready;

        if (state_q inside {SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP}) begin
            div_d = phase_done ? '0 : div_q + DIV_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (tick) begin
                    if (out_free) begin
                        ch_d    = 1'b0;
                        sout_d  = CMD_CH0;
                        bit_d   = '0;
                        state_d = SETUP;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (phase_done) begin
                    state_d = SHIFT_HI;
                    sin_d   = {sin_q[14:0], miso};
                    bit_d   = bit_q + 5'd1;
                end
            end
            SHIFT_HI: begin
                if (phase_done) begin
                    state_d = SHIFT_LO;
                    sout_d  = {sout_q[14:0], 1'b0};
                end
            end
            SHIFT_LO: begin
                // The low half-period after the 16th rising edge is kept so SCLK stays 50% duty.
                if (phase_done) begin
                    if (bit_q == 5'd16) begin
                        state_d = HOLD;
                    end else begin
                        state_d = SHIFT_HI;
                        sin_d   = {sin_q[14:0], miso};
                        bit_d   = bit_q + 5'd1;
                    end
                end
            end
            HOLD: begin
                if (phase_done) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (phase_done) begin
                    if (out_free) begin
                        load = 1'b1;
                    end else begin
                        state_d = WAIT_OUT;
                    end
                end
            end
            WAIT_OUT: begin
                if (out_free) begin
                    load = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q != IDLE && tick) begin
            overrun_d = 1'b1;
        end

        // A ch0 load launches the ch1 frame on the same edge; a ch1 load closes the pair.
        if (load) begin
            m_data_d  = sin_q;
            m_valid_d = 1'b1;
            m_last_d  = ch_q;
            div_d     = '0;
            if (!ch_q) begin
                ch_d    = 1'b1;
                sout_d  = CMD_CH1;
                bit_d   = '0;
                state_d = SETUP;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            ch_q      <= 1'b0;
            sout_q    <= '0;
            sin_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            ch_q      <= ch_d;
            sout_q    <= sout_d;
            sin_q     <= sin_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            overrun_q <= overrun_d;
        end
    end

    // SPI pins decode straight from state so reset takes them idle without a clock edge.
    assign in_frame = state_q inside {SETUP, SHIFT_HI, SHIFT_LO, HOLD};
    assign cs_n     = !in_frame;
    assign sclk     = (state_q == SHIFT_HI);
    assign mosi     = in_frame && sout_q[15];

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;
    assign overrun  = overrun_q;

endmodule

// File: doc/axis_spi_adc_pair.md
# axis_spi_adc_pair

SPI master that reads a two-channel ADC and emits the results as an AXI-Stream-style sample stream, feeding the two-sample averaging stage directly downstream. Every `SAMPLE_INTERVAL` clocks it runs one SPI frame per channel, channel 0 then channel 1. It presents each 16-bit result on `m_data`, with `m_last` marking the channel-1 word that closes the pair. It never drops half a pair and reports missed sample ticks on `overrun`.

## Interface
- `CLK_DIV`, 4: clk cycles per SCLK half-period (≥1).
- `SAMPLE_INTERVAL`, 1000: clk cycles between pair-start ticks (≥ 72*CLK_DIV for no overruns).
- `CMD_CH0`, 16'h0000: command word shifted out on MOSI for channel 0.
- `CMD_CH1`, 16'h0800: command word shifted out on MOSI for channel 1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  run free-running sampling.
- `sclk`  out  1  SPI clock, idle low.
- `cs_n`  out  1  SPI chip select, active low.
- `mosi`  out  1  SPI data to ADC.
- `miso`  in  1  SPI data from ADC.
- `m_valid`  out  1  output word valid.
- `m_data`  out  16  received ADC word, MSB first as shifted in.
- `m_last`  out  1  high with the channel-1 word.
- `m_ready`  in  1  downstream accepts word.
- `overrun`  out  1  one-cycle pulse when a tick is skipped.

## Operation
- Reset values: `sclk`=0, `cs_n`=1, `mosi`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `overrun`=0; interval counter 0; state IDLE.
- Interval counter:
  - Counts 0..SAMPLE_INTERVAL-1 while `enable`=1, then wraps.
  - Held at 0 while `enable`=0.
  - `tick` fires in the cycle where count = SAMPLE_INTERVAL-1.
- States: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP, WAIT_OUT.
- IDLE:
  - On `tick`, if the output register is free (`m_valid`=0, or `m_valid`&`m_ready` this cycle): select ch0, load the shift-out register with CMD_CH0, go to SETUP.
  - On `tick` otherwise: pulse `overrun`, stay in IDLE.
- `tick` while not in IDLE (pair in progress): pulse `overrun`, ignore the tick.
- SETUP: `cs_n`=0, `sclk`=0, `mosi`=cmd[15], CLK_DIV cycles.
- SHIFT_HI: `sclk`=1 for CLK_DIV cycles; `miso` is captured into the shift-in LSB on the edge that enters SHIFT_HI (SCLK 0→1).
- SHIFT_LO:
  - `sclk`=0 for CLK_DIV cycles; `mosi` advances to the next command bit on entry (SCLK 1→0).
  - After the 16th SHIFT_HI, go to HOLD instead.
- HOLD: `sclk`=0, `cs_n`=0, CLK_DIV cycles.
- GAP: `cs_n`=1, CLK_DIV cycles. At the end, load the output if it is free, otherwise go to WAIT_OUT.
- WAIT_OUT: stay until the output is free, then load.
- Output load:
  - `m_data`←shift-in, `m_valid`←1, `m_last`←(channel==1).
  - After a ch0 load, go to SETUP with CMD_CH1; after a ch1 load, go to IDLE.
- Output handshake:
  - Word transfers when `m_valid`&`m_ready`.
  - `m_valid` clears the next edge unless a new load happens on the same edge, in which case it stays 1 and the data is replaced.
  - `m_data`/`m_last` are stable while `m_valid`&!`m_ready`.
- `enable` falling mid-pair: the current pair finishes (both words emitted), then IDLE.
- `rst` mid-frame: all outputs return to reset values immediately (asynchronous). The partial frame is discarded and no word is emitted.

## Timing
- Frame length: 35*CLK_DIV clk cycles, from `cs_n` falling to GAP end (1 SETUP + 32 half-periods + 1 HOLD + 1 GAP).
- `tick` at edge T0 → `cs_n` low after T0 → ch0 `m_valid`=1 after edge T0+35*CLK_DIV, with no backpressure.
- The ch1 frame starts on the same edge as the ch0 load; ch1 `m_valid` follows after a further 35*CLK_DIV.
- SCLK period is 2*CLK_DIV clk cycles with 50% duty; 16 rising edges per frame.
- `cs_n` minimum high time between frames is CLK_DIV cycles.
- Backpressure on `m_ready` only stretches WAIT_OUT. SPI timing inside a frame is never stalled.

## Test plan
- CLK_DIV=2, SAMPLE_INTERVAL=200, ADC model returns 16'hA5C3 (ch0) and 16'h1234 (ch1), `m_ready`=1 → words A5C3/last=0 at tick+70 and 1234/last=1 at tick+140; MOSI bits equal CMD_CH0/CMD_CH1; exactly 16 SCLK rises per `cs_n` low window.
- Same setup, `m_ready`=0 for 300 cycles after the first word → A5C3 held stable; FSM waits in WAIT_OUT; 1234 appears the cycle after release; next tick → `overrun` pulse.
- SAMPLE_INTERVAL=100, CLK_DIV=2 (pair needs 140) → `overrun` pulses on every other tick; no word lost or duplicated; `m_last` strictly alternates 0,1.
- `enable` deasserted 10 cycles into the ch0 frame → both words of that pair emitted, then `cs_n` stays high and no further ticks occur.
- `rst` asserted mid-SHIFT_HI → `cs_n`=1, `sclk`=0, `m_valid`=0 without waiting for a clock edge; after release with `enable`=1, the first word appears at SAMPLE_INTERVAL+35*CLK_DIV.
